frame_generator: RTL and testbench
==================================

// Module: frame_generator
// PURPOSE
//  Transmit-side counterpart of the frame aligner: packs a buffered payload byte stream into
//  fixed frames and drives one byte per clock onto tx_data.
//  Frame = header LSB (8'hAA or 8'h55) + header MSB (8'hAF or 8'hBA) + PAYLOAD_LEN payload bytes.
//  Outside frames the block drives IDLE_BYTE. Sits in front of the serial link; its
//  tx_data feeds rx_data of a frame aligner in loopback benches.
// PARAMETERS
//  PAYLOAD_LEN  10       payload bytes per frame; fixed at 10 to match the aligner
//  FIFO_DEPTH   16       payload FIFO entries; power of 2, >= PAYLOAD_LEN
//  GAP_BYTES    0        IDLE_BYTE cycles forced between frames (0..15)
//  IDLE_BYTE    8'h00    filler byte; must not equal 8'hAA or 8'h55
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  reset         in   1   asynchronous, active-low reset
//  pl_data       in   8   payload byte
//  pl_valid      in   1   pl_data valid
//  pl_ready      out  1   FIFO can accept a byte; push on pl_valid & pl_ready
//  hdr_type      in   1   0: AA/AF header, 1: 55/BA header; sampled at frame start
//  tx_en         in   1   permit new frames; a frame in progress always completes
//  tx_data       out  8   transmitted byte, registered
//  tx_byte_pos   out  4   0 = hdr LSB, 1 = hdr MSB, 2..11 = payload; 0 outside frames
//  frame_start   out  1   1-cycle pulse, coincident with the header-LSB byte on tx_data
//  frames_sent   out  16  count of completed frames; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (reset = 0, async):
//   - FSM -> IDLE; FIFO emptied.
//   - tx_data = IDLE_BYTE; tx_byte_pos = 0; frame_start = 0; frames_sent = 0.
//   - pl_ready = 1 the first cycle after reset release.
//   - Reset mid-frame aborts the frame; the partial frame is not counted.
//  FIFO:
//   - pl_ready = !full.
//   - Simultaneous push and pop: count unchanged.
//   - No push when full; no pop when empty (cannot occur in DATA, by start rule).
//  FSM states: IDLE, HLSB, HMSB, DATA, GAP.
//   - IDLE: tx_data = IDLE_BYTE. Go to HLSB when tx_en & fifo_count >= PAYLOAD_LEN;
//     hdr_type is latched on that same edge.
//   - HLSB (1 cycle): tx_data = hdr_type ? 8'h55 : 8'hAA; frame_start = 1; tx_byte_pos = 0.
//   - HMSB (1 cycle): tx_data = hdr_type ? 8'hBA : 8'hAF; tx_byte_pos = 1.
//   - DATA (PAYLOAD_LEN cycles): pop one FIFO byte per cycle onto tx_data; tx_byte_pos = 2..11.
//     On the last payload byte: frames_sent increments; next state is GAP if GAP_BYTES > 0,
//     else IDLE start check.
//   - GAP_BYTES = 0: when start conditions hold, HLSB follows the last payload byte directly
//     (back-to-back frames, no filler byte).
//   - GAP: tx_data = IDLE_BYTE for exactly GAP_BYTES cycles, then IDLE.
//  Latency: start condition true in IDLE at edge N -> header LSB on tx_data after edge N+1.
//  tx_en deasserted mid-frame: no effect until the frame completes; then hold IDLE.
//  hdr_type changes mid-frame are ignored.
//  Payload bytes equal to 8'hAA/8'h55 are sent unmodified (no escaping).
// CONFIGURATION
//  FRAME_GEN_ERR_INJ_EN defined:
//   - Adds input err_inj (1 bit), sampled with hdr_type at frame start.
//   - If set, that frame's header MSB is sent bit-inverted (8'h50 / 8'h45); the rest of
//     the frame is unchanged and it is still counted in frames_sent.
//  Not defined: no err_inj port; headers always legal.
// TESTING
//  1. Push 10 bytes 8'h01..8'h0A, hdr_type = 0, tx_en = 1
//     -> tx_data AA, AF, 01..0A, then IDLE_BYTE; frames_sent = 1; one frame_start pulse.
//  2. Push 30 bytes, GAP_BYTES = 0, hdr_type = 1
//     -> 3 back-to-back 12-byte frames headed 55/BA; loopback aligner frame_detect = 1.
//  3. Push 9 bytes -> tx_data stays IDLE_BYTE; the 10th push starts a frame 2 cycles later.
//  4. Fill FIFO to 16 with tx_en = 0 -> pl_ready = 0; next push ignored;
//     tx_en = 1 -> frame starts and pl_ready returns to 1 on the first payload pop.
//  5. Assert reset at tx_byte_pos = 5 -> tx_data = IDLE_BYTE immediately; FIFO empty;
//     frames_sent = 0.
//  6. (FRAME_GEN_ERR_INJ_EN) err_inj = 1 with hdr_type = 0 -> header AA,50;
//     loopback aligner rejects the frame and legal_frame_counter resets.

Source files
------------

// File: rtl/frame_generator.sv
// Packs buffered payload bytes into fixed frames (2-byte header + PAYLOAD_LEN bytes).
// Optional macro FRAME_GEN_ERR_INJ_EN adds err_inj to send a frame with an inverted header MSB.
module frame_generator #(
  parameter int unsigned PAYLOAD_LEN = 10,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned GAP_BYTES   = 0,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic        hdr_type,
`ifdef FRAME_GEN_ERR_INJ_EN
  input  logic        err_inj,
`endif
  input  logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [3:0]  tx_byte_pos,
  output logic        frame_start,
  output logic [15:0] frames_sent
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN - 1);
  localparam logic [3:0] GAP_LAST = (GAP_BYTES == 0) ? 4'd0 : 4'(GAP_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HLSB, S_HMSB, S_DATA, S_GAP} state_t;

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [3:0]      r_idx;
  logic [3:0]      r_gap;
  logic            r_hdr;
  logic            r_err;
  logic [7:0]      r_tx_data;
  logic [3:0]      r_pos;
  logic            r_fs;
  logic [15:0]     r_frames;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_last_data;
  logic w_gap_done;
  logic w_launch;
  logic w_err_in;

`ifdef FRAME_GEN_ERR_INJ_EN
  assign w_err_in = err_inj;
`else
  assign w_err_in = 1'b0;
`endif

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_push   = pl_valid & ~w_full;
  assign w_pop    = (r_state == S_DATA);
  assign pl_ready = ~w_full;

  assign w_last_data = (r_state == S_DATA) && (r_idx == LAST_IDX);
  assign w_gap_done  = (r_state == S_GAP) && (r_gap == GAP_LAST);

  // On the last payload pop the byte being popped is still counted, hence the strict '>'
  // so the next frame can never underrun the FIFO.
  assign w_launch = tx_en &&
                    (((r_state == S_IDLE) && (r_count >= CW'(PAYLOAD_LEN))) ||
                     (w_last_data && (GAP_BYTES == 0) && (r_count > CW'(PAYLOAD_LEN))) ||
                     (w_gap_done && (r_count >= CW'(PAYLOAD_LEN))));

  // NOTE: payload storage carries no reset; the pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pl_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_gap     <= '0;
      r_hdr     <= 1'b0;
      r_err     <= 1'b0;
      r_tx_data <= IDLE_BYTE;
      r_pos     <= '0;
      r_fs      <= 1'b0;
      r_frames  <= '0;
    end else begin
      r_fs <= 1'b0;
      if (w_launch) begin
        r_hdr <= hdr_type;
        r_err <= w_err_in;
      end
      case (r_state)
        S_IDLE: begin
          r_tx_data <= IDLE_BYTE;
          r_pos     <= '0;
          if (w_launch) r_state <= S_HLSB;
        end
        S_HLSB: begin
          r_tx_data <= r_hdr ? 8'h55 : 8'hAA;
          r_pos     <= 4'd0;
          r_fs      <= 1'b1;
          r_state   <= S_HMSB;
        end
        S_HMSB: begin
          r_tx_data <= (r_hdr ? 8'hBA : 8'hAF) ^ {8{r_err}};
          r_pos     <= 4'd1;
          r_idx     <= '0;
          r_state   <= S_DATA;
        end
        S_DATA: begin
          r_tx_data <= r_mem[r_rd_ptr];
          r_pos     <= 4'd2 + r_idx;
          r_idx     <= r_idx + 1'b1;
          if (w_last_data) begin
            r_frames <= r_frames + 1'b1;
            r_idx    <= '0;
            if (GAP_BYTES > 0) begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_state <= w_launch ? S_HLSB : S_IDLE;
            end
          end
        end
        S_GAP: begin
          r_tx_data <= IDLE_BYTE;
          r_pos     <= '0;
          r_gap     <= r_gap + 1'b1;
          if (w_gap_done) r_state <= w_launch ? S_HLSB : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_byte_pos = r_pos;
  assign frame_start = r_fs;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_frame_generator.sv
// Directed bench for frame_generator: vector table for single frames, hand sequences for
// back-to-back frames, FIFO-full backpressure, mid-frame reset and optional error injection.
module tb_frame_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        hdr_type;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [3:0]  tx_byte_pos;
  logic        frame_start;
  logic [15:0] frames_sent;
`ifdef FRAME_GEN_ERR_INJ_EN
  logic        err_inj;
`endif

  int n_checks = 0;
  int n_errors = 0;

  frame_generator dut (
    .clk         (clk),
    .reset       (reset),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .hdr_type    (hdr_type),
`ifdef FRAME_GEN_ERR_INJ_EN
    .err_inj     (err_inj),
`endif
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_byte_pos (tx_byte_pos),
    .frame_start (frame_start),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        hdr;
    logic        en;
    logic [7:0]  e_tx;
    logic [3:0]  e_pos;
    logic        e_fs;
    logic        e_rdy;
    logic [15:0] e_frames;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic h, input logic en,
                     input logic [7:0] etx, input logic [3:0] epos, input logic efs,
                     input logic [15:0] efr);
    vec_t r;
    r.valid = v; r.data = d; r.hdr = h; r.en = en;
    r.e_tx = etx; r.e_pos = epos; r.e_fs = efs; r.e_rdy = 1'b1; r.e_frames = efr;
    vq.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t3 [10];
    logic [7:0] q [$];
    logic [7:0] exp_b;
    logic [7:0] first_b;
    logic       rdy;
    logic       found;
    int         idx;
    int         pulses;
    bit         started;

    t3 = '{8'hAA, 8'h55, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    // Test 1: one frame AA/AF, payload 01..0A; hdr_type flips mid-frame and is ignored.
    for (int i = 0; i < 10; i++) add(1, 8'h01 + 8'(i), 0, 1, 8'h00, 4'd0, 0, 16'd0);
    add(0, 8'h00, 0, 1, 8'h00, 4'd0, 0, 16'd0);
    add(0, 8'h00, 1, 1, 8'hAA, 4'd0, 1, 16'd0);
    add(0, 8'h00, 1, 1, 8'hAF, 4'd1, 0, 16'd0);
    for (int i = 0; i < 10; i++)
      add(0, 8'h00, 1, 1, 8'h01 + 8'(i), 4'd2 + 4'(i), 0, (i == 9) ? 16'd1 : 16'd0);
    add(0, 8'h00, 1, 1, 8'h00, 4'd0, 0, 16'd1);
    add(0, 8'h00, 1, 1, 8'h00, 4'd0, 0, 16'd1);
    // Test 3: nine bytes stay idle; the tenth starts a frame two cycles later (55/BA, AA/55 unescaped).
    for (int i = 0; i < 9; i++) add(1, t3[i], 1, 1, 8'h00, 4'd0, 0, 16'd1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 1, 1, 8'h00, 4'd0, 0, 16'd1);
    add(1, t3[9], 1, 1, 8'h00, 4'd0, 0, 16'd1);
    add(0, 8'h00, 1, 1, 8'h00, 4'd0, 0, 16'd1);
    add(0, 8'h00, 1, 1, 8'h55, 4'd0, 1, 16'd1);
    add(0, 8'h00, 1, 1, 8'hBA, 4'd1, 0, 16'd1);
    for (int i = 0; i < 10; i++)
      add(0, 8'h00, 1, 1, t3[i], 4'd2 + 4'(i), 0, (i == 9) ? 16'd2 : 16'd1);
    add(0, 8'h00, 1, 1, 8'h00, 4'd0, 0, 16'd2);

    reset = 1'b0; pl_data = '0; pl_valid = 1'b0; hdr_type = 1'b0; tx_en = 1'b0;
`ifdef FRAME_GEN_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    #13;
    check("reset tx_data", tx_data, 8'h00);
    check("reset tx_byte_pos", tx_byte_pos, 4'd0);
    check("reset frame_start", frame_start, 1'b0);
    check("reset frames_sent", frames_sent, 16'd0);
    tick();
    reset = 1'b1;
    check("post-reset pl_ready", pl_ready, 1'b1);

    foreach (vq[i]) begin
      pl_valid = vq[i].valid; pl_data = vq[i].data; hdr_type = vq[i].hdr; tx_en = vq[i].en;
      tick();
      check($sformatf("vec%0d tx_data", i), tx_data, vq[i].e_tx);
      check($sformatf("vec%0d tx_byte_pos", i), tx_byte_pos, vq[i].e_pos);
      check($sformatf("vec%0d frame_start", i), frame_start, vq[i].e_fs);
      check($sformatf("vec%0d pl_ready", i), pl_ready, vq[i].e_rdy);
      check($sformatf("vec%0d frames_sent", i), frames_sent, vq[i].e_frames);
    end

    // Test 2: 30 bytes with handshake -> three contiguous 55/BA frames.
    hdr_type = 1'b1; tx_en = 1'b1; idx = 0; pulses = 0; started = 0;
    for (int c = 0; c < 80; c++) begin
      pl_valid = (idx < 30);
      pl_data  = 8'h20 + 8'(idx);
      rdy = pl_ready;
      tick();
      if (pl_valid && rdy) idx++;
      if (frame_start) begin pulses++; started = 1; end
      if (started && q.size() < 36) q.push_back(tx_data);
    end
    pl_valid = 1'b0;
    check("t2 captured bytes", q.size(), 36);
    for (int i = 0; i < q.size(); i++) begin
      if (i % 12 == 0)      exp_b = 8'h55;
      else if (i % 12 == 1) exp_b = 8'hBA;
      else                  exp_b = 8'h20 + 8'((i / 12) * 10 + (i % 12) - 2);
      check($sformatf("t2 byte%0d", i), q[i], exp_b);
    end
    check("t2 frame_start pulses", pulses, 3);
    check("t2 frames_sent", frames_sent, 16'd5);

    // Test 4: fill FIFO with tx_en low, overflow push ignored, pl_ready back on first pop.
    tx_en = 1'b0; hdr_type = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pl_valid = 1'b1; pl_data = 8'h40 + 8'(i);
      tick();
    end
    check("t4 full pl_ready", pl_ready, 1'b0);
    pl_data = 8'hEE;
    tick();
    pl_valid = 1'b0;
    check("t4 overflow pl_ready", pl_ready, 1'b0);
    check("t4 held idle", tx_data, 8'h00);
    tx_en = 1'b1;
    tick();
    check("t4 start cycle tx", tx_data, 8'h00);
    tick();
    check("t4 hdr lsb", tx_data, 8'hAA);
    check("t4 frame_start", frame_start, 1'b1);
    tick();
    check("t4 hdr msb", tx_data, 8'hAF);
    check("t4 ready before pop", pl_ready, 1'b0);
    tick();
    check("t4 ready after pop", pl_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      check($sformatf("t4 payload%0d", i), tx_data, 8'h40 + 8'(i));
    end
    check("t4 frames_sent", frames_sent, 16'd6);
    tick();
    check("t4 idle after frame", tx_data, 8'h00);

    // Test 5: four more bytes complete a frame; reset at tx_byte_pos 5 aborts it.
    for (int i = 0; i < 4; i++) begin
      pl_valid = 1'b1; pl_data = 8'h50 + 8'(i);
      tick();
    end
    pl_valid = 1'b0; found = 1'b0; first_b = 8'h00;
    for (int c = 0; c < 30 && !found; c++) begin
      tick();
      if (tx_byte_pos == 4'd2) first_b = tx_data;
      if (tx_byte_pos == 4'd5) found = 1'b1;
    end
    check("t5 reached pos5", found, 1'b1);
    check("t5 first payload", first_b, 8'h4A);
    #2 reset = 1'b0;
    #1;
    check("t5 reset tx_data", tx_data, 8'h00);
    check("t5 reset tx_byte_pos", tx_byte_pos, 4'd0);
    check("t5 reset frames_sent", frames_sent, 16'd0);
    check("t5 reset pl_ready", pl_ready, 1'b1);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (frame_start) pulses++;
    end
    check("t5 fifo empty no frame", pulses, 0);
    for (int i = 0; i < 10; i++) begin
      pl_valid = 1'b1; pl_data = 8'h60 + 8'(i);
      tick();
    end
    pl_valid = 1'b0; first_b = 8'h00;
    for (int c = 0; c < 30 && frames_sent != 16'd1; c++) begin
      tick();
      if (tx_byte_pos == 4'd2) first_b = tx_data;
    end
    check("t5 frames after reset", frames_sent, 16'd1);
    check("t5 fresh payload", first_b, 8'h60);

`ifdef FRAME_GEN_ERR_INJ_EN
    // Test 6: injected error inverts the header MSB only.
    err_inj = 1'b1; hdr_type = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pl_valid = 1'b1; pl_data = 8'h70 + 8'(i);
      tick();
    end
    pl_valid = 1'b0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (frame_start) found = 1'b1;
    end
    check("t6 frame started", found, 1'b1);
    check("t6 hdr lsb", tx_data, 8'hAA);
    err_inj = 1'b0;
    tick();
    check("t6 hdr msb inverted", tx_data, 8'h50);
    tick();
    check("t6 payload0", tx_data, 8'h70);
    for (int c = 0; c < 20 && frames_sent != 16'd2; c++) tick();
    check("t6 frame counted", frames_sent, 16'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
